// File: rtl/pwm_fade_sequencer.sv
// Breathing-fade controller for one pwm instance: ramps duty min->max, holds, ramps
// max->min, holds and loops. Duty updates land only on shadow PWM period boundaries.
module pwm_fade_sequencer #(
  parameter int N          = 8,
  parameter int PRESCALE_W = 16,
  parameter int HOLD_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [N-1:0]          duty_min,
  input  logic [N-1:0]          duty_max,
  input  logic [HOLD_W-1:0]     hold_periods,
  output logic                  ena,
  output logic                  step,
  output logic [N-1:0]          duty,
  output logic                  busy,
  output logic                  cycle_done,
  output logic                  cfg_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD_HIGH = 3'd2,
    RAMP_DOWN = 3'd3,
    HOLD_LOW  = 3'd4
  } state_t;

  state_t                r_state, w_nstate;
  logic [PRESCALE_W-1:0] r_pcnt, r_prescale_q;
  logic [N-1:0]          r_pcount, r_duty, r_min_q, r_max_q;
  logic [HOLD_W-1:0]     r_hcnt, r_hold_q;
  logic                  r_stop_pend, r_cycle_done, r_cfg_err;

  logic                  w_run, w_step, w_pend, w_hold_zero, w_hold_done;
  logic [HOLD_W-1:0]     w_hold_last;
  logic [N-1:0]          w_duty_nxt;
  logic [HOLD_W-1:0]     w_hcnt_nxt;
  logic                  w_done_nxt, w_err_nxt, w_latch;

  // Outputs that must fall with async reset are decoded straight from state.
  assign w_run       = (r_state != IDLE);
  assign w_step      = w_run && (r_pcnt == r_prescale_q);
  assign w_pend      = w_step && (&r_pcount);
  assign w_hold_zero = (r_hold_q == '0);
  assign w_hold_last = r_hold_q - HOLD_W'(1);
  assign w_hold_done = (r_hcnt == w_hold_last);

  assign ena        = w_run;
  assign busy       = w_run;
  assign step       = w_step;
  assign duty       = r_duty;
  assign cycle_done = r_cycle_done;
  assign cfg_err    = r_cfg_err;

  always_comb begin
    w_nstate   = r_state;
    w_duty_nxt = r_duty;
    w_hcnt_nxt = r_hcnt;
    w_done_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    w_latch    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_duty_nxt = '0;
        w_hcnt_nxt = '0;
        if (start && !stop) begin
          if (duty_min > duty_max) begin
            w_err_nxt = 1'b1;
          end else begin
            w_latch    = 1'b1;
            w_duty_nxt = duty_min;
            w_nstate   = RAMP_UP;
          end
        end
      end
      RAMP_UP: begin
        if (w_pend) begin
          if (r_duty == r_max_q) begin
            w_hcnt_nxt = '0;
            w_nstate   = w_hold_zero ? RAMP_DOWN : HOLD_HIGH;
          end else begin
            w_duty_nxt = r_duty + N'(1);
          end
        end
      end
      HOLD_HIGH: begin
        if (w_pend) begin
          if (w_hold_done) begin
            w_hcnt_nxt = '0;
            w_nstate   = RAMP_DOWN;
          end else begin
            w_hcnt_nxt = r_hcnt + HOLD_W'(1);
          end
        end
      end
      RAMP_DOWN: begin
        if (w_pend) begin
          if (r_duty == r_min_q) begin
            w_hcnt_nxt = '0;
            if (r_stop_pend) begin
              w_nstate   = IDLE;
              w_duty_nxt = '0;
              w_done_nxt = 1'b1;
            end else if (w_hold_zero) begin
              w_nstate   = RAMP_UP;
              w_done_nxt = 1'b1;
            end else begin
              w_nstate   = HOLD_LOW;
            end
          end else begin
            w_duty_nxt = r_duty - N'(1);
          end
        end
      end
      HOLD_LOW: begin
        if (w_pend) begin
          if (w_hold_done) begin
            w_hcnt_nxt = '0;
            w_nstate   = RAMP_UP;
            w_done_nxt = 1'b1;
          end else begin
            w_hcnt_nxt = r_hcnt + HOLD_W'(1);
          end
        end
      end
      default: begin
        w_nstate   = IDLE;
        w_duty_nxt = '0;
        w_hcnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_duty       <= '0;
      r_hcnt       <= '0;
      r_cycle_done <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_state      <= w_nstate;
      r_duty       <= w_duty_nxt;
      r_hcnt       <= w_hcnt_nxt;
      r_cycle_done <= w_done_nxt;
      r_cfg_err    <= w_err_nxt;
    end
  end

  // Prescaler and shadow period counter sit at zero in IDLE so a fresh start
  // lines up with a freshly enabled pwm counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt   <= '0;
      r_pcount <= '0;
    end else if (!w_run) begin
      r_pcnt   <= '0;
      r_pcount <= '0;
    end else if (w_step) begin
      r_pcnt   <= '0;
      r_pcount <= r_pcount + N'(1);
    end else begin
      r_pcnt   <= r_pcnt + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stop_pend <= 1'b0;
    end else if (!w_run) begin
      r_stop_pend <= 1'b0;
    end else if (stop) begin
      r_stop_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prescale_q <= '0;
      r_min_q      <= '0;
      r_max_q      <= '0;
      r_hold_q     <= '0;
    end else if (w_latch) begin
      r_prescale_q <= prescale;
      r_min_q      <= duty_min;
      r_max_q      <= duty_max;
      r_hold_q     <= hold_periods;
    end
  end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: directed scenarios plus random traffic, checked each
// clock against a time-indexed model of the fade schedule.
module tb_pwm_fade_sequencer;
  localparam int N  = 4;
  localparam int PW = 4;
  localparam int HW = 4;
  localparam int NP = 1 << N;

  logic          clk = 1'b0;
  logic          rst, start, stop;
  logic [PW-1:0] prescale;
  logic [N-1:0]  duty_min, duty_max;
  logic [HW-1:0] hold_periods;
  logic          ena, step, busy, cycle_done, cfg_err;
  logic [N-1:0]  duty;

  pwm_fade_sequencer #(.N(N), .PRESCALE_W(PW), .HOLD_W(HW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .prescale(prescale),
    .duty_min(duty_min), .duty_max(duty_max), .hold_periods(hold_periods),
    .ena(ena), .step(step), .duty(duty), .busy(busy),
    .cycle_done(cycle_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: m_t = clocks since start; the schedule is a list of periods per fade cycle.
  bit m_run, m_stop, m_done, m_err;
  int m_t, m_min, m_max, m_hold, m_p;

  function automatic int per_clks();
    return NP * (m_p + 1);
  endfunction

  function automatic int cyc_len();
    return 2 * (m_max - m_min + 1) + 2 * m_hold;
  endfunction

  function automatic int exp_duty();
    int r, p;
    if (!m_run) return 0;
    r = m_max - m_min + 1;
    p = (m_t / per_clks()) % cyc_len();
    if (p < r)              return m_min + p;
    if (p < r + m_hold)     return m_max;
    if (p < 2*r + m_hold)   return m_max - (p - r - m_hold);
    return m_min;
  endfunction

  function automatic int exp_step();
    return (m_run && (m_t % (m_p + 1)) == m_p) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_run = 0; m_stop = 0; m_done = 0; m_err = 0; m_t = 0;
  endtask

  task automatic model_edge(input bit s, input bit sp, input int pre, input int mn,
                            input int mx, input int hd);
    bit pe;
    int k, r, l;
    m_done = 0;
    m_err  = 0;
    if (!m_run) begin
      if (s && !sp) begin
        if (mn > mx) m_err = 1;
        else begin
          m_p = pre; m_min = mn; m_max = mx; m_hold = hd;
          m_run = 1; m_t = 0; m_stop = 0;
        end
      end
    end else begin
      r  = m_max - m_min + 1;
      l  = cyc_len();
      k  = m_t / per_clks();
      pe = (exp_step() != 0) && ((m_t / (m_p + 1)) % NP == NP - 1);
      if (pe && (k % l) == 2*r + m_hold - 1 && m_stop) begin
        m_run  = 0;
        m_done = 1;
      end else begin
        if (pe && ((k + 1) % l) == 0) m_done = 1;
        m_t++;
        if (sp) m_stop = 1;
      end
    end
  endtask

  task automatic cycle(input bit s, input bit sp, input int pre, input int mn,
                       input int mx, input int hd, input bit ar);
    start = s; stop = sp;
    prescale = PW'(pre); duty_min = N'(mn); duty_max = N'(mx); hold_periods = HW'(hd);
    if (ar) begin
      #2 rst = 1'b1;
      #1;
      chk("rst_ena", ena, 0);
      chk("rst_step", step, 0);
      chk("rst_duty", duty, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      model_reset();
    end
    @(negedge clk);
    chk("ena", ena, m_run);
    chk("busy", busy, m_run);
    chk("step", step, exp_step());
    chk("duty", duty, exp_duty());
    chk("cycle_done", cycle_done, m_done);
    chk("cfg_err", cfg_err, m_err);
    @(posedge clk);
    #1;
    model_edge(s, sp, pre, mn, mx, hd);
  endtask

  // Idle traffic: config inputs wander every clock and must be ignored while running.
  task automatic noise(input int n);
    for (int i = 0; i < n; i++)
      cycle(0, 0, $urandom % 3, $urandom % NP, $urandom % NP, $urandom % 4, 0);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget && m_run; i++) noise(1);
    chk("idle_timeout", (i < budget) ? 0 : 1, 0);
  endtask

  task automatic run_until_duty(input int d, input int budget);
    int i;
    for (i = 0; i < budget && !(m_run && exp_duty() == d); i++) noise(1);
    chk("duty_timeout", (i < budget) ? 0 : 1, 0);
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0;
    prescale = '0; duty_min = '0; duty_max = '0; hold_periods = '0;
    model_reset();
    #1;
    chk("por_ena", ena, 0);
    chk("por_duty", duty, 0);
    chk("por_cycle_done", cycle_done, 0);
    chk("por_cfg_err", cfg_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    noise(3);

    // Reset mid-ramp at duty 5, then stay idle.
    cycle(1, 0, 0, 0, 15, 0, 0);
    run_until_duty(5, 200);
    cycle(0, 0, 0, 0, 15, 0, 1);
    noise(40);

    // prescale 2, 0..3, no hold; start while ramping with other config is ignored.
    cycle(1, 0, 2, 0, 3, 0, 0);
    noise(700);
    cycle(1, 0, 1, 5, 9, 3, 0);
    noise(700);
    cycle(0, 1, 0, 0, 0, 0, 0);
    wait_idle(3000);

    // Holds of 2 periods at each bound.
    cycle(1, 0, 0, 2, 4, 2, 0);
    noise(500);
    cycle(0, 1, 0, 0, 0, 0, 0);
    wait_idle(3000);

    // Graceful stop while ramping up at duty 6, with extra stops ignored.
    cycle(1, 0, 0, 1, 8, 1, 0);
    run_until_duty(6, 2000);
    cycle(0, 1, 0, 1, 8, 1, 0);
    noise(100);
    cycle(0, 1, 0, 1, 8, 1, 0);
    wait_idle(5000);
    cycle(0, 1, 0, 0, 0, 0, 0);
    noise(10);

    // Rejected config, then min == max.
    cycle(1, 0, 0, 9, 3, 0, 0);
    noise(5);
    cycle(1, 0, 0, 7, 7, 0, 0);
    noise(200);
    cycle(0, 1, 0, 0, 0, 0, 0);
    wait_idle(500);
    cycle(1, 0, 1, 7, 7, 2, 0);
    noise(400);
    cycle(0, 1, 0, 0, 0, 0, 0);
    wait_idle(1000);

    // Simultaneous start and stop in IDLE: stop wins, even with a bad config.
    cycle(1, 1, 0, 2, 5, 0, 0);
    noise(3);
    cycle(1, 1, 0, 9, 3, 0, 0);
    noise(3);

    // Random traffic.
    for (int i = 0; i < 40000; i++) begin
      int mn, mx;
      bit s, sp;
      mn = $urandom % NP;
      mx = ($urandom % 8 == 0) ? mn : $urandom % NP;
      s  = ($urandom % 150 == 0);
      sp = ($urandom % 1200 == 0) || (s && $urandom % 10 == 0);
      cycle(s, sp, $urandom % 3, mn, mx, $urandom % 4, ($urandom % 6000 == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
